// File: rtl/fuzz_mem_model_if.sv
// Request/response bundle between the core's imem/dmem ports and the fuzzing memory model.
interface fuzz_mem_model_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              imem_req_valid;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_resp_valid;
  logic [XLEN-1:0]   imem_resp_data;

  logic              dmem_req_valid;
  logic              dmem_req_ready;
  logic [ADDR_W-1:0] dmem_req_addr;
  logic [XLEN-1:0]   dmem_req_data;
  logic              dmem_req_write_en;
  logic [XLEN/8-1:0] dmem_req_wstrb;
  logic              dmem_resp_valid;
  logic [XLEN-1:0]   dmem_resp_data;
  logic              dmem_resp_ready;

  modport master (
    output imem_req_valid, imem_req_addr,
    output dmem_req_valid, dmem_req_addr, dmem_req_data, dmem_req_write_en, dmem_req_wstrb,
    output dmem_resp_ready,
    input  imem_resp_valid, imem_resp_data,
    input  dmem_req_ready, dmem_resp_valid, dmem_resp_data
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    input  dmem_req_valid, dmem_req_addr, dmem_req_data, dmem_req_write_en, dmem_req_wstrb,
    input  dmem_resp_ready,
    output imem_resp_valid, imem_resp_data,
    output dmem_req_ready, dmem_resp_valid, dmem_resp_data
  );
endinterface

// File: rtl/fuzz_mem_model.sv
// Fuzzing memory model: first-touch filled instruction store (from generator) and data store
// (from LFSR), with read latency pipeline, response FIFO and initial-memory snapshot port.
module fuzz_mem_model #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned IDX_W      = 10,
  parameter int unsigned DMEM_LAT   = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          RD_CURRENT = 1'b1,
  parameter logic [31:0] LFSR_SEED  = 32'hACE12468
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fuzz_mem_model_if.slave       bus,
  output logic                  gen_req,
  input  logic [XLEN-1:0]       gen_data,
  input  logic [IDX_W-1:0]      snap_idx,
  output logic [XLEN-1:0]       snap_data,
  output logic                  snap_touched,
  output logic [IDX_W:0]        dmem_touched_cnt
);
  localparam int unsigned WORDS  = 1 << IDX_W;
  localparam int unsigned NB     = XLEN / 8;
  localparam int unsigned REP    = XLEN / 32;
  localparam int unsigned TCNT_W = IDX_W + 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [31:0] TAPS   = 32'h80200003;

  // Only the word-index field of either address takes part in lookup.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.imem_req_addr[ADDR_W-1:IDX_W+2], bus.imem_req_addr[1:0],
                              bus.dmem_req_addr[ADDR_W-1:IDX_W+2], bus.dmem_req_addr[1:0]};

  // ---------------- instruction store ----------------
  logic [XLEN-1:0]  imem_mem [WORDS];
  logic [WORDS-1:0] imem_touched;
  logic [IDX_W-1:0] imem_idx;
  logic             imem_hit;
  logic             imem_rv;
  logic [XLEN-1:0]  imem_rd;

  assign imem_idx = bus.imem_req_addr[IDX_W+1:2];
  assign imem_hit = imem_touched[imem_idx];
  assign gen_req  = bus.imem_req_valid & ~imem_hit;
  assign bus.imem_resp_valid = imem_rv;
  assign bus.imem_resp_data  = imem_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_touched <= '0;
      imem_rv      <= 1'b0;
      imem_rd      <= '0;
    end else begin
      imem_rv <= bus.imem_req_valid;
      if (bus.imem_req_valid) begin
        imem_rd <= imem_hit ? imem_mem[imem_idx] : gen_data;
        if (!imem_hit) imem_touched[imem_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (gen_req) imem_mem[imem_idx] <= gen_data;
  end

  // ---------------- data store ----------------
  logic [XLEN-1:0]  dmem_init [WORDS];
  logic [XLEN-1:0]  dmem_cur  [WORDS];
  logic [WORDS-1:0] dmem_touched;
  logic [31:0]      lfsr;
  logic [31:0]      lfsr_next;
  logic [IDX_W-1:0] d_idx;
  logic             d_hit, d_acc, d_fill, d_rd;
  logic [XLEN-1:0]  fill_word, wr_word, rd_word;

  assign d_idx     = bus.dmem_req_addr[IDX_W+1:2];
  assign d_hit     = dmem_touched[d_idx];
  assign d_acc     = bus.dmem_req_valid & bus.dmem_req_ready;
  assign d_fill    = d_acc & ~d_hit;
  assign d_rd      = d_acc & ~bus.dmem_req_write_en;
  assign fill_word = {REP{lfsr}};
  assign lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'h0);

  // Write merges onto current contents, or onto the fill value for a first touch.
  always_comb begin
    wr_word = d_hit ? dmem_cur[d_idx] : fill_word;
    for (int b = 0; b < NB; b++) begin
      if (bus.dmem_req_wstrb[b]) wr_word[b*8 +: 8] = bus.dmem_req_data[b*8 +: 8];
    end
    rd_word = fill_word;
    if (d_hit) rd_word = RD_CURRENT ? dmem_cur[d_idx] : dmem_init[d_idx];
  end

  always_ff @(posedge clk) begin
    if (d_fill) dmem_init[d_idx] <= fill_word;
    if (d_acc && (bus.dmem_req_write_en || !d_hit))
      dmem_cur[d_idx] <= bus.dmem_req_write_en ? wr_word : fill_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_touched     <= '0;
      lfsr             <= LFSR_SEED;
      dmem_touched_cnt <= '0;
    end else if (d_fill) begin
      dmem_touched[d_idx] <= 1'b1;
      lfsr                <= lfsr_next;
      dmem_touched_cnt    <= dmem_touched_cnt + TCNT_W'(1);
    end
  end

  // Snapshot forwards a fill landing on the same index this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_data    <= '0;
      snap_touched <= 1'b0;
    end else if (d_fill && (d_idx == snap_idx)) begin
      snap_data    <= fill_word;
      snap_touched <= 1'b1;
    end else begin
      snap_data    <= dmem_touched[snap_idx] ? dmem_init[snap_idx] : '0;
      snap_touched <= dmem_touched[snap_idx];
    end
  end

  // ---------------- read latency pipeline ----------------
  logic            push_v;
  logic [XLEN-1:0] push_d;

  generate
    if (DMEM_LAT == 1) begin : g_lat1
      assign push_v = d_rd;
      assign push_d = rd_word;
    end else begin : g_latn
      logic [DMEM_LAT-2:0] pv;
      logic [XLEN-1:0]     pd [DMEM_LAT-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pv <= '0;
        end else begin
          pv[0] <= d_rd;
          for (int k = 1; k < DMEM_LAT - 1; k++) pv[k] <= pv[k-1];
        end
      end

      always_ff @(posedge clk) begin
        pd[0] <= rd_word;
        for (int k = 1; k < DMEM_LAT - 1; k++) pd[k] <= pd[k-1];
      end

      assign push_v = pv[DMEM_LAT-2];
      assign push_d = pd[DMEM_LAT-2];
    end
  endgenerate

  // ---------------- response FIFO ----------------
  logic [XLEN-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_cnt, infl_cnt;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Slots are reserved at accept so in-flight reads can never overflow the FIFO.
  assign bus.dmem_req_ready  = (32'(fifo_cnt) + 32'(infl_cnt)) < 32'(FIFO_DEPTH);
  assign bus.dmem_resp_valid = (fifo_cnt != '0);
  assign bus.dmem_resp_data  = bus.dmem_resp_valid ? fifo_mem[rd_ptr] : '0;
  assign pop                 = bus.dmem_resp_valid & bus.dmem_resp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      infl_cnt <= '0;
    end else begin
      if (push_v) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)    rd_ptr <= ptr_inc(rd_ptr);
      fifo_cnt <= fifo_cnt + CNT_W'(push_v) - CNT_W'(pop);
      infl_cnt <= infl_cnt + CNT_W'(d_rd) - CNT_W'(push_v);
    end
  end

  always_ff @(posedge clk) begin
    if (push_v) fifo_mem[wr_ptr] <= push_d;
  end
endmodule

// File: tb/tb_fuzz_mem_model.sv
// Self-checking bench for fuzz_mem_model: directed vector tables, corner sequences and
// randomized traffic against a queue/array reference model.
module tb_fuzz_mem_model;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned IDX_W  = 10;
  localparam int unsigned LAT    = 1;
  localparam int unsigned DEPTH  = 4;
  localparam bit          RDC    = 1'b1;
  localparam logic [31:0] SEED   = 32'hACE12468;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              gen_req;
  logic [XLEN-1:0]   gen_data;
  logic [IDX_W-1:0]  snap_idx;
  logic [XLEN-1:0]   snap_data;
  logic              snap_touched;
  logic [IDX_W:0]    dmem_touched_cnt;

  fuzz_mem_model_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

  fuzz_mem_model #(
    .XLEN(XLEN), .ADDR_W(ADDR_W), .IDX_W(IDX_W), .DMEM_LAT(LAT),
    .FIFO_DEPTH(DEPTH), .RD_CURRENT(RDC), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .gen_req(gen_req), .gen_data(gen_data),
    .snap_idx(snap_idx), .snap_data(snap_data), .snap_touched(snap_touched),
    .dmem_touched_cnt(dmem_touched_cnt)
  );

  always #5 clk = ~clk;

  int checks, errors;

  // Reference model state
  typedef struct { logic [31:0] data; int due; } rsp_t;
  logic [31:0] m_imem [int];
  bit          m_itouch [int];
  logic [31:0] m_init [int];
  logic [31:0] m_cur [int];
  bit          m_dtouch [int];
  logic [31:0] m_lfsr;
  int          m_cnt;
  rsp_t        m_rq [$];
  bit          m_ivalid;
  logic [31:0] m_idata;
  int          cyc;
  bit          last_acc;
  int          dut_pops;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lfsr_step(logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
  endfunction

  function automatic int idx_of(logic [31:0] a);
    return int'((a >> 2) & 32'((1 << IDX_W) - 1));
  endfunction

  task automatic model_reset();
    m_itouch.delete();
    m_dtouch.delete();
    m_rq.delete();
    m_lfsr   = SEED;
    m_cnt    = 0;
    m_ivalid = 1'b0;
    m_idata  = 32'h0;
  endtask

  task automatic set_idle();
    bus.imem_req_valid    = 1'b0;
    bus.imem_req_addr     = '0;
    gen_data              = '0;
    bus.dmem_req_valid    = 1'b0;
    bus.dmem_req_addr     = '0;
    bus.dmem_req_data     = '0;
    bus.dmem_req_write_en = 1'b0;
    bus.dmem_req_wstrb    = '0;
    bus.dmem_resp_ready   = 1'b1;
    snap_idx              = '0;
  endtask

  // One clock: check combinational outputs, advance the model, then check registered outputs.
  task automatic tick();
    int ii, di, si;
    bit ihit, vis, rdy, acc, pop;
    logic [31:0] w;
    rsp_t r;
    #1;
    ii   = idx_of(bus.imem_req_addr);
    ihit = m_itouch.exists(ii);
    chk("gen_req", 32'(gen_req), 32'(bus.imem_req_valid && !ihit));
    vis = (m_rq.size() > 0) && (m_rq[0].due <= cyc);
    rdy = m_rq.size() < int'(DEPTH);
    chk("dmem_req_ready", 32'(bus.dmem_req_ready), 32'(rdy));
    if (bus.dmem_resp_valid && bus.dmem_resp_ready) dut_pops++;
    pop = vis && bus.dmem_resp_ready;
    acc = bus.dmem_req_valid && rdy;
    last_acc = acc;
    m_ivalid = bus.imem_req_valid;
    if (bus.imem_req_valid) begin
      if (!ihit) begin
        m_imem[ii]   = gen_data;
        m_itouch[ii] = 1'b1;
      end
      m_idata = m_imem[ii];
    end
    if (pop) void'(m_rq.pop_front());
    if (acc) begin
      di = idx_of(bus.dmem_req_addr);
      if (!m_dtouch.exists(di)) begin
        m_init[di]   = m_lfsr;
        m_cur[di]    = m_lfsr;
        m_dtouch[di] = 1'b1;
        m_lfsr       = lfsr_step(m_lfsr);
        m_cnt++;
      end
      if (bus.dmem_req_write_en) begin
        w = m_cur[di];
        for (int b = 0; b < 4; b++)
          if (bus.dmem_req_wstrb[b]) w[b*8 +: 8] = bus.dmem_req_data[b*8 +: 8];
        m_cur[di] = w;
      end else begin
        r.data = RDC ? m_cur[di] : m_init[di];
        r.due  = cyc + int'(LAT);
        m_rq.push_back(r);
      end
    end
    si = int'(snap_idx);
    @(posedge clk);
    cyc++;
    #1;
    chk("imem_resp_valid", 32'(bus.imem_resp_valid), 32'(m_ivalid));
    chk("imem_resp_data", bus.imem_resp_data, m_idata);
    vis = (m_rq.size() > 0) && (m_rq[0].due <= cyc);
    chk("dmem_resp_valid", 32'(bus.dmem_resp_valid), 32'(vis));
    if (vis) chk("dmem_resp_data", bus.dmem_resp_data, m_rq[0].data);
    chk("snap_touched", 32'(snap_touched), 32'(m_dtouch.exists(si)));
    if (m_dtouch.exists(si)) chk("snap_data", snap_data, m_init[si]);
    chk("dmem_touched_cnt", 32'(dmem_touched_cnt), 32'(m_cnt));
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_imem_resp_valid", 32'(bus.imem_resp_valid), 32'h0);
    chk("rst_imem_resp_data", bus.imem_resp_data, 32'h0);
    chk("rst_dmem_resp_valid", 32'(bus.dmem_resp_valid), 32'h0);
    chk("rst_touched_cnt", 32'(dmem_touched_cnt), 32'h0);
    chk("rst_snap_touched", 32'(snap_touched), 32'h0);
    chk("rst_snap_data", snap_data, 32'h0);
    chk("rst_req_ready", 32'(bus.dmem_req_ready), 32'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] gen;
    logic        exp_req;
    logic [31:0] exp_data;
  } ivec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
    logic [3:0]  strb;
    logic [9:0]  sidx;
    logic        ev;
    logic [31:0] ed;
    int          ecnt;
    logic [31:0] esd;
    logic        est;
  } dvec_t;

  ivec_t itab [6];
  dvec_t dtab [10];

  initial begin
    int nxt, budget, p0;
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    dut_pops = 0;

    itab[0] = '{32'h0000_0000, 32'h0000_0013, 1'b1, 32'h0000_0013};
    itab[1] = '{32'h0000_0004, 32'h0010_0093, 1'b1, 32'h0010_0093};
    itab[2] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0013};
    itab[3] = '{32'h0000_1000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0013};
    itab[4] = '{32'h0000_1006, 32'h1234_5678, 1'b0, 32'h0010_0093};
    itab[5] = '{32'h0000_0008, 32'h1234_5678, 1'b1, 32'h1234_5678};

    dtab[0] = '{32'h100,  32'h0,        1'b0, 4'h0, 10'h40, 1'b1, 32'hACE12468, 1, 32'hACE12468, 1'b1};
    dtab[1] = '{32'h200,  32'hDEADBEEF, 1'b1, 4'h3, 10'h80, 1'b0, 32'h0,        2, 32'h56709234, 1'b1};
    dtab[2] = '{32'h200,  32'h0,        1'b0, 4'h0, 10'h80, 1'b1, 32'h5670BEEF, 2, 32'h56709234, 1'b1};
    dtab[3] = '{32'h000,  32'h0,        1'b0, 4'h0, 10'h00, 1'b1, 32'h2B38491A, 3, 32'h2B38491A, 1'b1};
    dtab[4] = '{32'h1000, 32'h0,        1'b0, 4'h0, 10'h03, 1'b1, 32'h2B38491A, 3, 32'h0,        1'b0};
    dtab[5] = '{32'h1002, 32'h11223344, 1'b1, 4'hC, 10'h00, 1'b0, 32'h0,        3, 32'h2B38491A, 1'b1};
    dtab[6] = '{32'h000,  32'h0,        1'b0, 4'h0, 10'h00, 1'b1, 32'h1122491A, 3, 32'h2B38491A, 1'b1};
    dtab[7] = '{32'h300,  32'hAAAAAAAA, 1'b1, 4'h0, 10'hC0, 1'b0, 32'h0,        4, 32'h159C248D, 1'b1};
    dtab[8] = '{32'h300,  32'h0,        1'b0, 4'h0, 10'hC0, 1'b1, 32'h159C248D, 4, 32'h159C248D, 1'b1};
    dtab[9] = '{32'h304,  32'h0,        1'b0, 4'h0, 10'hC1, 1'b1, 32'h8AEE1245, 5, 32'h8AEE1245, 1'b1};

    do_reset();

    // Instruction fetch table: misses pull from the generator, hits and aliases do not.
    for (int i = 0; i < 6; i++) begin
      set_idle();
      bus.imem_req_valid = 1'b1;
      bus.imem_req_addr  = itab[i].addr;
      gen_data           = itab[i].gen;
      #1;
      chk("tab_gen_req", 32'(gen_req), 32'(itab[i].exp_req));
      tick();
      chk("tab_imem_valid", 32'(bus.imem_resp_valid), 32'h1);
      chk("tab_imem_data", bus.imem_resp_data, itab[i].exp_data);
    end
    set_idle();
    tick();
    chk("imem_hold_data", bus.imem_resp_data, 32'h1234_5678);

    // Data store table: fills, strobed writes, aliasing, snapshot and counter.
    for (int i = 0; i < 10; i++) begin
      set_idle();
      bus.dmem_req_valid    = 1'b1;
      bus.dmem_req_addr     = dtab[i].addr;
      bus.dmem_req_data     = dtab[i].data;
      bus.dmem_req_write_en = dtab[i].we;
      bus.dmem_req_wstrb    = dtab[i].strb;
      snap_idx              = dtab[i].sidx;
      tick();
      chk("tab_resp_valid", 32'(bus.dmem_resp_valid), 32'(dtab[i].ev));
      if (dtab[i].ev) chk("tab_resp_data", bus.dmem_resp_data, dtab[i].ed);
      chk("tab_touched_cnt", 32'(dmem_touched_cnt), 32'(dtab[i].ecnt));
      chk("tab_snap_touched", 32'(snap_touched), 32'(dtab[i].est));
      if (dtab[i].est) chk("tab_snap_data", snap_data, dtab[i].esd);
    end
    set_idle();
    repeat (2) tick();

    // Backpressure: responses held, ready drops after DEPTH accepts, then drain in order.
    bus.dmem_resp_ready = 1'b0;
    nxt = 0;
    p0  = dut_pops;
    repeat (8) begin
      bus.dmem_req_valid = 1'b1;
      bus.dmem_req_addr  = 32'(nxt * 4);
      tick();
      if (last_acc) nxt++;
    end
    chk("bp_accepts_blocked", 32'(nxt), 32'(DEPTH));
    chk("bp_ready_low", 32'(bus.dmem_req_ready), 32'h0);
    bus.dmem_resp_ready = 1'b1;
    budget = 0;
    while (nxt < 8 && budget < 40) begin
      bus.dmem_req_addr = 32'(nxt * 4);
      tick();
      if (last_acc) nxt++;
      budget++;
    end
    bus.dmem_req_valid = 1'b0;
    budget = 0;
    while (bus.dmem_resp_valid && budget < 20) begin
      tick();
      budget++;
    end
    chk("bp_all_accepted", 32'(nxt), 32'd8);
    chk("bp_responses", 32'(dut_pops - p0), 32'd8);
    chk("bp_empty", 32'(bus.dmem_resp_valid), 32'h0);

    // Reset with reads pending: everything discarded, LFSR restarts at the seed.
    set_idle();
    bus.dmem_resp_ready = 1'b0;
    bus.dmem_req_valid  = 1'b1;
    bus.dmem_req_addr   = 32'h40;
    tick();
    bus.dmem_req_addr   = 32'h44;
    tick();
    bus.dmem_req_valid  = 1'b0;
    chk("rst_pre_pending", 32'(bus.dmem_resp_valid), 32'h1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_async_resp_valid", 32'(bus.dmem_resp_valid), 32'h0);
    chk("rst_async_cnt", 32'(dmem_touched_cnt), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.dmem_resp_ready = 1'b1;
    repeat (5) tick();
    bus.dmem_req_valid = 1'b1;
    bus.dmem_req_addr  = 32'h0;
    tick();
    chk("rst_seed_refill", bus.dmem_resp_data, 32'hACE12468);
    set_idle();
    tick();

    // Randomized concurrent traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) do_reset();
      bus.imem_req_valid    = ($urandom_range(0, 3) != 0);
      bus.imem_req_addr     = 32'(($urandom_range(0, 3) << 12) | ($urandom_range(0, 47) << 2) | $urandom_range(0, 3));
      gen_data              = $urandom;
      bus.dmem_req_valid    = ($urandom_range(0, 2) != 0);
      bus.dmem_req_addr     = 32'(($urandom_range(0, 3) << 12) | ($urandom_range(0, 63) << 2) | $urandom_range(0, 3));
      bus.dmem_req_data     = $urandom;
      bus.dmem_req_write_en = ($urandom_range(0, 1) != 0);
      bus.dmem_req_wstrb    = 4'($urandom);
      bus.dmem_resp_ready   = ($urandom_range(0, 3) != 0);
      snap_idx              = 10'($urandom_range(0, 63));
      tick();
    end
    set_idle();
    budget = 0;
    while (bus.dmem_resp_valid && budget < 20) begin
      tick();
      budget++;
    end
    chk("final_drained", 32'(bus.dmem_resp_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
